// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: instruction-sequencing FSM, condition-flag
// register, condition check and gating of every architectural write.
module multicycle_controller #(
  parameter int unsigned ALUCTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          Instr,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic                 RegWrite,
  output logic [3:0]           State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;   // {N,Z,C,V}
  logic       condex_q, condex_d;

  // Instruction fields (Instr holds IR[31:12])
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       i_bit, s_bit, l_bit;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign cmd       = funct[4:1];
  assign i_bit     = funct[5];
  assign s_bit     = funct[0];
  assign l_bit     = funct[0];
  assign unused_rn = ^Instr[7:4];

  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};
  assign State  = state_q;

  // Data-processing decode: ALU op, write suppression and flag-update class
  logic [3:0] dp_alu;
  logic       no_write, arith_op, logic_op;
  always_comb begin
    dp_alu   = ALU_ADD;
    no_write = 1'b0;
    arith_op = 1'b0;
    logic_op = 1'b0;
    unique case (cmd)
      4'b0100: begin dp_alu = ALU_ADD; arith_op = 1'b1; end
      4'b0010: begin dp_alu = ALU_SUB; arith_op = 1'b1; end
      4'b0000: begin dp_alu = ALU_AND; logic_op = 1'b1; end
      4'b1100: begin dp_alu = ALU_ORR; logic_op = 1'b1; end
      4'b0001: begin dp_alu = ALU_EOR; logic_op = 1'b1; end
      4'b1010: begin dp_alu = ALU_SUB; arith_op = 1'b1; no_write = 1'b1; end
      default: begin dp_alu = ALU_ADD; no_write = 1'b1; end
    endcase
  end

  // ARM condition check against the stored flags
  logic cond_ok;
  logic fn, fz, fc, fv;
  assign {fn, fz, fc, fv} = flags_q;
  always_comb begin
    cond_ok = 1'b0;
    unique case (cond)
      4'b0000: cond_ok = fz;
      4'b0001: cond_ok = ~fz;
      4'b0010: cond_ok = fc;
      4'b0011: cond_ok = ~fc;
      4'b0100: cond_ok = fn;
      4'b0101: cond_ok = ~fn;
      4'b0110: cond_ok = fv;
      4'b0111: cond_ok = ~fv;
      4'b1000: cond_ok = fc & ~fz;
      4'b1001: cond_ok = ~fc | fz;
      4'b1010: cond_ok = (fn == fv);
      4'b1011: cond_ok = (fn != fv);
      4'b1100: cond_ok = ~fz & (fn == fv);
      4'b1101: cond_ok = fz | (fn != fv);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Next state and raw per-state control
  logic       regw, memw, branch, irw, fetch;
  logic [3:0] alu_op;
  always_comb begin
    state_d   = FETCH;
    regw      = 1'b0;
    memw      = 1'b0;
    branch    = 1'b0;
    irw       = 1'b0;
    fetch     = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    alu_op    = ALU_ADD;
    unique case (state_q)
      FETCH: begin
        state_d = DECODE;
        fetch = 1'b1; irw = 1'b1;
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      DECODE: begin
        unique case (op)
          2'b00:   state_d = i_bit ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      MEMADR: begin
        state_d = l_bit ? MEMRD : MEMWR;
        ALUSrcB = 2'b01;
      end
      MEMRD: begin
        state_d = MEMWB;
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        // address kept on ALUOut through writeback so the read word is stable
        AdrSrc = 1'b1; ResultSrc = 2'b01; regw = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1; memw = 1'b1;
      end
      EXECUTER: begin
        state_d = ALUWB;
        alu_op = dp_alu;
      end
      EXECUTEI: begin
        state_d = ALUWB;
        ALUSrcB = 2'b01; alu_op = dp_alu;
      end
      ALUWB: regw = ~no_write;
      BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  assign ALUControl = ALUCTRL_W'(alu_op);

  // Write gating: condition result latched in DECODE, and reset blocks all writes
  assign RegWrite = regw & condex_q & reset;
  assign MemWrite = memw & condex_q & reset;
  assign IRWrite  = irw & reset;
  assign PCWrite  = (fetch | ((branch | (regw & (rd == 4'hF))) & condex_q)) & reset;

  // Condition latch and flag-register next values
  always_comb begin
    condex_d = condex_q;
    flags_d  = flags_q;
    if (state_q == DECODE) condex_d = cond_ok;
    if (((state_q == EXECUTER) || (state_q == EXECUTEI)) && s_bit && condex_q) begin
      if (arith_op)      flags_d = ALUFlags;
      else if (logic_op) flags_d[3:2] = ALUFlags[3:2];
    end
  end

  // State, flag and condition registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      flags_q  <= '0;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed per-cycle vector bench for multicycle_controller.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [3:0]  ALUControl, State;

  multicycle_controller #(.ALUCTRL_W(4)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .RegWrite(RegWrite), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] instr;
    logic [3:0]  flags;
    logic [3:0]  st;
    logic        pcw, adr, mw, irw;
    logic [1:0]  rs;
    logic        asa;
    logic [1:0]  asb;
    logic [3:0]  aluc;
    logic [1:0]  imm, rsrc;
    logic        rw;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(input logic [19:0] i, input logic [3:0] f, input logic [3:0] st,
                              input logic pcw, input logic adr, input logic mw, input logic irw,
                              input logic [1:0] rs, input logic asa, input logic [1:0] asb,
                              input logic [3:0] aluc, input logic [1:0] imm,
                              input logic [1:0] rsrc, input logic rw);
    vec_t v;
    v.instr = i; v.flags = f; v.st = st; v.pcw = pcw; v.adr = adr; v.mw = mw; v.irw = irw;
    v.rs = rs; v.asa = asa; v.asb = asb; v.aluc = aluc; v.imm = imm; v.rsrc = rsrc; v.rw = rw;
    return v;
  endfunction

  // Drive one cycle's inputs just after the edge, compare mid-cycle, advance.
  task automatic apply(input vec_t v, input string name);
    logic [21:0] act, exp;
    Instr = v.instr; ALUFlags = v.flags;
    #2;
    act = {State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegSrc, RegWrite};
    exp = {v.st, v.pcw, v.adr, v.mw, v.irw, v.rs, v.asa, v.asb, v.aluc, v.imm, v.rsrc, v.rw};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s instr=%h: got %b required %b", name, v.instr, act, exp);
    end
    @(posedge clk); #1;
  endtask

  // Common FETCH / DECODE rows for a given instruction
  task automatic add_fd(input logic [19:0] i, input logic [1:0] imm, input logic [1:0] rsrc);
    vecs.push_back(mk(i, 4'h0, 4'd0, 1,0,0,1, 2'b10,1,2'b10,4'h0, imm,rsrc, 0));
    vecs.push_back(mk(i, 4'h0, 4'd1, 0,0,0,0, 2'b10,1,2'b10,4'h0, imm,rsrc, 0));
  endtask

  initial begin
    reset = 1'b0; Instr = '0; ALUFlags = '0;

    // ADD R1,R2,R3
    add_fd(20'hE0821, 2'b00, 2'b00);
    vecs.push_back(mk(20'hE0821, 4'hF, 4'd6, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 0));
    vecs.push_back(mk(20'hE0821, 4'h0, 4'd8, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 1));
    // LDR R1,[R2,#4]
    add_fd(20'hE5921, 2'b01, 2'b10);
    vecs.push_back(mk(20'hE5921, 4'h0, 4'd2, 0,0,0,0, 2'b00,0,2'b01,4'h0, 2'b01,2'b10, 0));
    vecs.push_back(mk(20'hE5921, 4'h0, 4'd3, 0,1,0,0, 2'b00,0,2'b00,4'h0, 2'b01,2'b10, 0));
    vecs.push_back(mk(20'hE5921, 4'h0, 4'd4, 0,1,0,0, 2'b01,0,2'b00,4'h0, 2'b01,2'b10, 1));
    // STR
    add_fd(20'hE5821, 2'b01, 2'b10);
    vecs.push_back(mk(20'hE5821, 4'h0, 4'd2, 0,0,0,0, 2'b00,0,2'b01,4'h0, 2'b01,2'b10, 0));
    vecs.push_back(mk(20'hE5821, 4'h0, 4'd5, 0,1,1,0, 2'b00,0,2'b00,4'h0, 2'b01,2'b10, 0));
    // B
    add_fd(20'hEA000, 2'b10, 2'b01);
    vecs.push_back(mk(20'hEA000, 4'h0, 4'd9, 1,0,0,0, 2'b10,0,2'b01,4'h0, 2'b10,2'b01, 0));
    // SUBS R0,R0,R0 with Z result -> Flags 0100
    add_fd(20'hE0500, 2'b00, 2'b00);
    vecs.push_back(mk(20'hE0500, 4'h4, 4'd6, 0,0,0,0, 2'b00,0,2'b00,4'h1, 2'b00,2'b00, 0));
    vecs.push_back(mk(20'hE0500, 4'h0, 4'd8, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 1));
    // ADDNE: suppressed
    add_fd(20'h10821, 2'b00, 2'b00);
    vecs.push_back(mk(20'h10821, 4'h0, 4'd6, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 0));
    vecs.push_back(mk(20'h10821, 4'h0, 4'd8, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 0));
    // ADDEQ: executes
    add_fd(20'h00821, 2'b00, 2'b00);
    vecs.push_back(mk(20'h00821, 4'h0, 4'd6, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 0));
    vecs.push_back(mk(20'h00821, 4'h0, 4'd8, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 1));
    // CMP R?,#imm with N result -> Flags 1000, no register write
    add_fd(20'hE3500, 2'b00, 2'b00);
    vecs.push_back(mk(20'hE3500, 4'h8, 4'd7, 0,0,0,0, 2'b00,0,2'b01,4'h1, 2'b00,2'b00, 0));
    vecs.push_back(mk(20'hE3500, 4'h0, 4'd8, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 0));
    // ADDLT PC,...: N!=V true, Rd=15 also writes PC
    add_fd(20'hB082F, 2'b00, 2'b00);
    vecs.push_back(mk(20'hB082F, 4'h0, 4'd6, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 0));
    vecs.push_back(mk(20'hB082F, 4'h0, 4'd8, 1,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 1));
    // ADDS with C,V result -> Flags 0011
    add_fd(20'hE0910, 2'b00, 2'b00);
    vecs.push_back(mk(20'hE0910, 4'h3, 4'd6, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 0));
    vecs.push_back(mk(20'hE0910, 4'h0, 4'd8, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 1));
    // ANDS with ALUFlags 0100: only N,Z taken -> Flags 0111
    add_fd(20'hE0110, 2'b00, 2'b00);
    vecs.push_back(mk(20'hE0110, 4'h4, 4'd6, 0,0,0,0, 2'b00,0,2'b00,4'h2, 2'b00,2'b00, 0));
    vecs.push_back(mk(20'hE0110, 4'h0, 4'd8, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 1));
    // ADDVS: V kept at 1 -> writes
    add_fd(20'h60821, 2'b00, 2'b00);
    vecs.push_back(mk(20'h60821, 4'h0, 4'd6, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 0));
    vecs.push_back(mk(20'h60821, 4'h0, 4'd8, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 1));
    // ADDHI: C=1 but Z=1 -> suppressed
    add_fd(20'h80821, 2'b00, 2'b00);
    vecs.push_back(mk(20'h80821, 4'h0, 4'd6, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 0));
    vecs.push_back(mk(20'h80821, 4'h0, 4'd8, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 0));
    // Unsupported cmd with S=1: NOP, no write, flags untouched
    add_fd(20'hE1F10, 2'b00, 2'b00);
    vecs.push_back(mk(20'hE1F10, 4'h8, 4'd6, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 0));
    vecs.push_back(mk(20'hE1F10, 4'h0, 4'd8, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 0));
    // ADDMI: N still 0 -> suppressed
    add_fd(20'h40821, 2'b00, 2'b00);
    vecs.push_back(mk(20'h40821, 4'h0, 4'd6, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 0));
    vecs.push_back(mk(20'h40821, 4'h0, 4'd8, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 0));
    // op=11: UNKNOWN, no writes
    add_fd(20'hEC000, 2'b11, 2'b00);
    vecs.push_back(mk(20'hEC000, 4'h0, 4'd10, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b11,2'b00, 0));
    // BNE with Z=1: no PC write
    add_fd(20'h1A000, 2'b10, 2'b01);
    vecs.push_back(mk(20'h1A000, 4'h0, 4'd9, 0,0,0,0, 2'b10,0,2'b01,4'h0, 2'b10,2'b01, 0));
    // STRNE with Z=1: no memory write
    add_fd(20'h15821, 2'b01, 2'b10);
    vecs.push_back(mk(20'h15821, 4'h0, 4'd2, 0,0,0,0, 2'b00,0,2'b01,4'h0, 2'b01,2'b10, 0));
    vecs.push_back(mk(20'h15821, 4'h0, 4'd5, 0,1,0,0, 2'b00,0,2'b00,4'h0, 2'b01,2'b10, 0));

    // Reset held for 3 cycles: enables off, state FETCH
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({State, PCWrite, IRWrite, MemWrite, RegWrite} !== 8'h00) begin
      fails++;
      $display("FAIL reset_hold: got %b required %b",
               {State, PCWrite, IRWrite, MemWrite, RegWrite}, 8'h00);
    end
    reset = 1'b1;

    foreach (vecs[k]) apply(vecs[k], $sformatf("vec%0d", k));

    // Reset during EXECUTER aborts the ADD
    apply(mk(20'hE0821, 4'h0, 4'd0, 1,0,0,1, 2'b10,1,2'b10,4'h0, 2'b00,2'b00, 0), "abort_fetch");
    apply(mk(20'hE0821, 4'h0, 4'd1, 0,0,0,0, 2'b10,1,2'b10,4'h0, 2'b00,2'b00, 0), "abort_decode");
    Instr = 20'hE0821; ALUFlags = 4'h0;
    #1 reset = 1'b0;
    #1;
    tests++;
    if ({State, PCWrite, IRWrite, MemWrite, RegWrite} !== 8'h00) begin
      fails++;
      $display("FAIL abort_immediate: got %b required %b",
               {State, PCWrite, IRWrite, MemWrite, RegWrite}, 8'h00);
    end
    @(posedge clk); #1;
    tests++;
    if ({State, RegWrite} !== 5'h00) begin
      fails++;
      $display("FAIL abort_no_writeback: got %b required %b", {State, RegWrite}, 5'h00);
    end
    reset = 1'b1;
    // Flags cleared by reset: ADDEQ must not write
    apply(mk(20'h00821, 4'h0, 4'd0, 1,0,0,1, 2'b10,1,2'b10,4'h0, 2'b00,2'b00, 0), "post_fetch");
    apply(mk(20'h00821, 4'h0, 4'd1, 0,0,0,0, 2'b10,1,2'b10,4'h0, 2'b00,2'b00, 0), "post_decode");
    apply(mk(20'h00821, 4'h0, 4'd6, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 0), "post_exec");
    apply(mk(20'h00821, 4'h0, 4'd8, 0,0,0,0, 2'b00,0,2'b00,4'h0, 2'b00,2'b00, 0), "post_aluwb");
    apply(mk(20'hE0821, 4'h0, 4'd0, 1,0,0,1, 2'b10,1,2'b10,4'h0, 2'b00,2'b00, 0), "post_refetch");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
